div_ratio_ctrl: RTL
===================

// Module: div_ratio_ctrl
// PURPOSE
//  Run-time controller for the integer clock divider on clk_in. Holds the active divide
//  ratio and generates the registered divided output plus a period-end tick.
//  Accepts new ratios over a valid/ready handshake and applies them only at a period
//  boundary, so clk_out never carries a runt pulse.
//  Start/stop is gated by run_en. Sits between the config register block and the
//  downstream logic that consumes clk_out/tick.
// PARAMETERS
//  CNT_W        8   width of the divide ratio and the period counter
//  DEFAULT_DIV  5   ratio loaded at reset; must be >= MIN_DIV
//  MIN_DIV      2   smallest legal ratio; smaller requests are rejected
// PORTS
//  clk_in     in   1      single clock; all logic on its rising edge
//  rst        in   1      synchronous reset, active-low
//  run_en     in   1      1 = divider running; 0 = stop at the next period end
//  cfg_valid  in   1      new ratio offered
//  cfg_div    in   CNT_W  offered ratio, unsigned
//  cfg_ready  out  1      1 = can accept a ratio this cycle
//  cfg_err    out  1      1-cycle pulse: offered ratio < MIN_DIV, discarded
//  cur_div    out  CNT_W  ratio currently applied
//  clk_out    out  1      divided output, registered
//  tick       out  1      1-cycle pulse in the last cycle of each period (cnt == cur_div-1)
//  busy       out  1      1 in RUN or PEND
// BEHAVIOUR
//  Reset (rst==0 at an edge): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend_div=0,
//   clk_out=0, tick=0, cfg_err=0, cfg_ready=1. Mid-operation reset aborts the period
//   and drops any pending ratio.
//  Counter: in RUN/PEND cnt runs 0..cur_div-1 then wraps to 0. In IDLE it is held at 0.
//  clk_out: the registered value is 1 when the next cnt < floor(cur_div/2), else 0.
//   High for floor(N/2) cycles and low for ceil(N/2) cycles. Example: N=5 gives 2 high / 3 low.
//   clk_out is 0 in IDLE.
//  Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready = (state != PEND).
//   A ratio < MIN_DIV sets cfg_err=1 for the next cycle, and state and ratio are unchanged.
//  FSM:
//   IDLE: a legal cfg updates cur_div immediately. run_en=1 -> RUN with cnt=0.
//         The first clk_out high appears 1 cycle after run_en is sampled.
//   RUN:  a legal cfg stores pend_div -> PEND. run_en=0 is latched as stop_req.
//   PEND: at the wrap edge (cnt==cur_div-1): cur_div<=pend_div, cnt<=0 -> RUN.
//         The new ratio governs the very next period.
//   stop: at a wrap with stop_req set -> IDLE and clk_out<=0. A pending ratio is applied
//         first at the same edge. A run_en re-assert before the wrap clears stop_req.
//  Simultaneous events:
//   - cfg accept and wrap on the same edge: the current period ends with the old ratio.
//     The new ratio applies from the following wrap.
//   - cfg_err and run_en changes are independent.
//  tick asserts in the cycle where cnt==cur_div-1 while RUN/PEND. No tick is produced in IDLE.
//  Width: compares are done at CNT_W bits. cur_div up to 2^CNT_W-1 is supported, with no overflow.
// STRUCTURE
//  Shared package div_pkg: state enum {IDLE,RUN,PEND} (2-bit), DIV_CNT_W, DIV_MIN, DIV_DEFAULT.
//  One sub-module: div_period_cnt. It contains the counter, wrap/tick detection and clk_out
//   generation, with inputs (en, div) and outputs (cnt, wrap, clk_out_nxt).
//   The FSM and handshake stay in the top module.
// TESTING
//  1. Reset, run_en=1, default 5 -> clk_out 2 high/3 low repeating; tick every 5 cycles;
//     cur_div=5.
//  2. In RUN, offer cfg_div=4 at cnt=1 -> cfg_ready drops next cycle. Period finishes at 5,
//     then 2 high/2 low; tick spacing becomes 4.
//  3. Offer cfg_div=1 -> cfg_err pulses once, cur_div stays 5, and the clk_out pattern is
//     unchanged.
//  4. Drop run_en at cnt=2 (div=5) -> the period completes; after the tick, clk_out=0,
//     busy=0, cnt=0.
//  5. Pending ratio 7 plus run_en=0 at the same period -> at the wrap, cur_div=7 and the FSM
//     enters IDLE. Re-enable gives 3 high/4 low.
//  6. rst=0 in PEND mid-period -> the next cycle shows cur_div=5, clk_out=0, cfg_ready=1, and
//     the pending ratio is lost.
//  7. cfg_div=255 -> 127 high/128 low; no counter overflow.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the run-time integer clock divider controller.
package div_pkg;

  localparam int DIV_CNT_W   = 8;
  localparam int DIV_MIN     = 2;
  localparam int DIV_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_period_cnt.sv
// Period counter: counts 0..div-1 while enabled and flags the wrap cycle.
// clk_out_nxt is combinational; it is the clk_out level for the cycle after this edge.
module div_period_cnt
  import div_pkg::*;
#(
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_clk_out_nxt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_wrap    = i_en && (r_cnt == (i_div - CNT_W'(1)));
  assign w_cnt_nxt = (!i_en || o_wrap) ? '0 : (r_cnt + CNT_W'(1));

  // High for the first floor(div/2) counts of each period.
  assign o_clk_out_nxt = (w_cnt_nxt < (i_div >> 1));
  assign o_cnt         = r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divider controller: ratio handshake, start/stop FSM and registered clk_out.
// New ratios take effect only at a period wrap; cfg_ready is low while one is pending.
module div_ratio_ctrl
  import div_pkg::*;
#(
  parameter int CNT_W       = DIV_CNT_W,
  parameter int DEFAULT_DIV = DIV_DEFAULT,
  parameter int MIN_DIV     = DIV_MIN
) (
  input  logic             i_clk_in,
  input  logic             i_rst,
  input  logic             i_run_en,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic [CNT_W-1:0] o_cur_div,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_busy
);

  div_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cur_div, w_cur_div_nxt;
  logic [CNT_W-1:0] r_pend_div, w_pend_div_nxt;
  logic             r_stop_req, w_stop_req_nxt;
  logic             r_clk_out, r_cfg_err;

  logic [CNT_W-1:0] w_cnt;
  logic             w_wrap, w_clk_out_nxt, w_cnt_en;
  logic             w_xfer, w_legal, w_accept, w_stop;

  assign w_cnt_en = (r_state != IDLE);

  div_period_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk         (i_clk_in),
    .i_rst         (i_rst),
    .i_en          (w_cnt_en),
    .i_div         (r_cur_div),
    .o_cnt         (w_cnt),
    .o_wrap        (w_wrap),
    .o_clk_out_nxt (w_clk_out_nxt)
  );

  assign o_cfg_ready = (r_state != PEND);
  assign w_xfer      = i_cfg_valid && o_cfg_ready;
  assign w_legal     = (i_cfg_div >= CNT_W'(MIN_DIV));
  assign w_accept    = w_xfer && w_legal;
  // A stop seen in any earlier cycle of the period, or at the wrap edge itself.
  assign w_stop      = r_stop_req || !i_run_en;

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_div_nxt  = r_cur_div;
    w_pend_div_nxt = r_pend_div;
    w_stop_req_nxt = r_stop_req;
    case (r_state)
      IDLE: begin
        w_stop_req_nxt = 1'b0;
        if (w_accept) w_cur_div_nxt = i_cfg_div;
        if (i_run_en) w_state_nxt = RUN;
      end
      RUN: begin
        w_stop_req_nxt = !i_run_en;
        if (w_wrap && w_stop) begin
          w_state_nxt    = IDLE;
          w_stop_req_nxt = 1'b0;
          if (w_accept) w_cur_div_nxt = i_cfg_div;
        end else if (w_accept) begin
          w_pend_div_nxt = i_cfg_div;
          w_state_nxt    = PEND;
        end
      end
      PEND: begin
        w_stop_req_nxt = !i_run_en;
        if (w_wrap) begin
          w_cur_div_nxt = r_pend_div;
          if (w_stop) begin
            w_state_nxt    = IDLE;
            w_stop_req_nxt = 1'b0;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_stop_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_in) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_cur_div  <= CNT_W'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_stop_req <= 1'b0;
      r_clk_out  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_div  <= w_cur_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_stop_req <= w_stop_req_nxt;
      r_clk_out  <= (w_state_nxt != IDLE) && w_clk_out_nxt;
      r_cfg_err  <= w_xfer && !w_legal;
    end
  end

  assign o_cfg_err = r_cfg_err;
  assign o_cur_div = r_cur_div;
  assign o_clk_out = r_clk_out;
  assign o_tick    = w_wrap;
  assign o_busy    = (r_state != IDLE);

  a_idle_cnt_zero: assert property (@(posedge i_clk_in) disable iff (!i_rst)
    (r_state == IDLE) |-> (w_cnt == '0));

endmodule
